pq_feeder: RTL and testbench

//  Front-end stage that sits directly upstream of the priority queue (pq_if device side).
//  It buffers incoming key/value items in a small FIFO and accepts dequeue requests.
//  It sequences one-cycle enq/deq pulses into the PQ, honouring full/busy/empty.
//  It returns dequeued items on a valid/ready output with an empty-error flag.

---
 rtl/pq_feeder.sv | 179 +++++++++++++++++
 tb/tb_pq_feeder.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pq_feeder.sv
// Front end for the priority queue: buffers incoming items in a small FIFO and
// sequences single-cycle enqueue/dequeue pulses into the PQ, returning dequeued items.
module pq_feeder #(
    parameter int KEY_WIDTH = 8,
    parameter int VAL_WIDTH = 8,
    parameter int DEPTH     = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_in_valid,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] i_in_kv,
    output logic                           o_in_ready,
    input  logic                           i_dq_valid,
    output logic                           o_dq_ready,
    output logic                           o_out_valid,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0] o_out_kv,
    output logic                           o_out_empty,
    input  logic                           i_out_ready,
    output logic                           o_pq_enq,
    output logic                           o_pq_deq,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0] o_pq_kvi,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] i_pq_kvo,
    input  logic                           i_pq_full,
    input  logic                           i_pq_empty,
    input  logic                           i_pq_busy
);

    localparam int W  = KEY_WIDTH + VAL_WIDTH;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENQ  = 2'd1,
        ST_DEQ  = 2'd2,
        ST_CAP  = 2'd3
    } state_t;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    state_t        r_state;
    logic          r_rr;
    logic          r_pq_enq;
    logic          r_pq_deq;
    logic [W-1:0]  r_pq_kvi;
    logic          r_dq_ready;
    logic          r_out_valid;
    logic [W-1:0]  r_out_kv;
    logic          r_out_empty;

    logic w_in_ready;
    logic w_push;
    logic w_pop;
    logic w_enq_ok;
    logic w_deq_ok;
    logic w_take_enq;
    logic w_take_deq;

    assign w_in_ready = (r_count < CW'(DEPTH));
    assign w_push     = i_in_valid & w_in_ready;
    assign w_pop      = (r_state == ST_ENQ);
    assign w_enq_ok   = (r_count != {CW{1'b0}}) & ~i_pq_full;
    assign w_deq_ok   = i_dq_valid & ~r_out_valid;

    // Arbitration in IDLE: round-robin only breaks a tie, otherwise the eligible op wins
    always_comb begin
        w_take_enq = 1'b0;
        w_take_deq = 1'b0;
        if ((r_state == ST_IDLE) && !i_pq_busy) begin
            if (w_enq_ok && w_deq_ok) begin
                w_take_enq = ~r_rr;
                w_take_deq = r_rr;
            end else begin
                w_take_enq = w_enq_ok;
                w_take_deq = w_deq_ok;
            end
        end else begin
            w_take_enq = 1'b0;
            w_take_deq = 1'b0;
        end
    end

    // FIFO storage write port; contents are don't-care until pointed at by count
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_in_kv;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sequencer: issues one PQ op at a time and owns the single result slot
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_rr        <= 1'b0;
            r_pq_enq    <= 1'b0;
            r_pq_deq    <= 1'b0;
            r_pq_kvi    <= {W{1'b0}};
            r_dq_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_kv    <= {W{1'b0}};
            r_out_empty <= 1'b0;
        end else begin
            r_pq_enq   <= 1'b0;
            r_pq_deq   <= 1'b0;
            r_dq_ready <= 1'b0;
            if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if ((w_take_enq || w_take_deq) && w_enq_ok && w_deq_ok) begin
                        r_rr <= ~r_rr;
                    end
                    if (w_take_enq) begin
                        r_pq_kvi <= r_mem[r_rd_ptr];
                        r_pq_enq <= 1'b1;
                        r_state  <= ST_ENQ;
                    end else if (w_take_deq) begin
                        r_dq_ready <= 1'b1;
                        // An empty PQ is answered locally without touching the PQ
                        if (i_pq_empty) begin
                            r_out_valid <= 1'b1;
                            r_out_empty <= 1'b1;
                            r_out_kv    <= {W{1'b0}};
                            r_state     <= ST_IDLE;
                        end else begin
                            r_pq_deq <= 1'b1;
                            r_state  <= ST_DEQ;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ENQ:  r_state <= ST_IDLE;
                ST_DEQ:  r_state <= ST_CAP;
                ST_CAP: begin
                    r_out_kv    <= i_pq_kvo;
                    r_out_valid <= 1'b1;
                    r_out_empty <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_dq_ready  = r_dq_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_kv    = r_out_kv;
    assign o_out_empty = r_out_empty;
    assign o_pq_enq    = r_pq_enq;
    assign o_pq_deq    = r_pq_deq;
    assign o_pq_kvi    = r_pq_kvi;

endmodule

// File: tb/tb_pq_feeder.sv
// Bench for pq_feeder: a behavioural priority queue plus scoreboards for enqueue order
// and dequeue results, driven by directed scenarios and a randomized phase.
module tb_pq_feeder;
    localparam int KW     = 8;
    localparam int VW     = 8;
    localparam int W      = KW + VW;
    localparam int DEPTH  = 4;
    localparam int PQ_CAP = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_kv = 16'h0000;
    logic         in_ready;
    logic         dq_valid = 1'b0;
    logic         dq_ready;
    logic         out_valid;
    logic [W-1:0] out_kv;
    logic         out_empty;
    logic         out_ready = 1'b0;
    logic         pq_enq;
    logic         pq_deq;
    logic [W-1:0] pq_kvi;
    logic [W-1:0] pq_kvo = 16'h0000;
    logic         pq_full;
    logic         pq_empty;
    logic         pq_busy = 1'b0;
    logic         force_full = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] pq_q[$];
    logic [W-1:0] enq_q[$];
    logic [W:0]   res_q[$];
    logic [W-1:0] enq_log[$];
    int           ops[$];
    int           pq_sz = 0;
    int           enq_cnt = 0;
    int           deq_cnt = 0;
    int           cyc = 0;
    int           last_deq_cyc = -100;

    assign pq_empty = (pq_sz == 0);
    assign pq_full  = (pq_sz >= PQ_CAP) || force_full;

    pq_feeder #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_in_kv(in_kv), .o_in_ready(in_ready),
        .i_dq_valid(dq_valid), .o_dq_ready(dq_ready), .o_out_valid(out_valid), .o_out_kv(out_kv),
        .o_out_empty(out_empty), .i_out_ready(out_ready), .o_pq_enq(pq_enq), .o_pq_deq(pq_deq),
        .o_pq_kvi(pq_kvi), .i_pq_kvo(pq_kvo), .i_pq_full(pq_full), .i_pq_empty(pq_empty),
        .i_pq_busy(pq_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // PQ model and protocol monitor, evaluated mid-cycle when all signals are stable
    task automatic monitor_loop();
        logic p_enq = 1'b0, p_deq = 1'b0, p_ov = 1'b0, p_busy = 1'b0, p_full = 1'b0;
        logic [W-1:0] e;
        logic [W:0]   r;
        int mi;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pq_q.delete(); enq_q.delete(); res_q.delete();
                pq_sz = 0; p_enq = 1'b0; p_deq = 1'b0; p_ov = 1'b0; p_busy = 1'b0; p_full = 1'b0;
            end else begin
                if (in_valid && in_ready) enq_q.push_back(in_kv);
                if (pq_enq || pq_deq || dq_ready) begin
                    checks++;
                    if ((pq_enq && pq_deq) || (pq_enq && p_enq) || (pq_deq && p_deq) || p_busy) begin
                        errors++;
                        $display("FAIL op_protocol enq=%b deq=%b prev_enq=%b prev_deq=%b busy_at_issue=%b", pq_enq, pq_deq, p_enq, p_deq, p_busy);
                    end
                end
                if (pq_enq) begin
                    checks++;
                    if (enq_q.size() == 0 || p_full) begin
                        errors++;
                        $display("FAIL enq_unexpected kvi=%h buffered=%0d full_at_issue=%b", pq_kvi, enq_q.size(), p_full);
                    end else begin
                        e = enq_q.pop_front();
                        if (pq_kvi !== e) begin
                            errors++;
                            $display("FAIL enq_order kvi=%h expected %h", pq_kvi, e);
                        end
                    end
                    pq_q.push_back(pq_kvi);
                    enq_log.push_back(pq_kvi);
                    enq_cnt++;
                    ops.push_back(0);
                end
                if (dq_ready && !pq_deq) begin
                    checks++;
                    if (pq_sz != 0) begin
                        errors++;
                        $display("FAIL deq_skipped pq_size=%0d expected 0", pq_sz);
                    end
                    res_q.push_back({1'b1, {W{1'b0}}});
                end
                if (pq_deq) begin
                    checks++;
                    if (pq_sz == 0) begin
                        errors++;
                        $display("FAIL deq_on_empty pq_size=%0d expected >0", pq_sz);
                    end else begin
                        mi = 0;
                        for (int i = 1; i < pq_q.size(); i++)
                            if (pq_q[i][W-1:VW] < pq_q[mi][W-1:VW]) mi = i;
                        pq_kvo = pq_q[mi];
                        pq_q.delete(mi);
                        res_q.push_back({1'b0, pq_kvo});
                    end
                    deq_cnt++;
                    last_deq_cyc = cyc;
                    ops.push_back(1);
                end
                pq_sz = pq_q.size();
                if (out_valid && !p_ov && !out_empty) begin
                    checks++;
                    if (cyc - last_deq_cyc != 2) begin
                        errors++;
                        $display("FAIL capture_latency got %0d cycles expected 2", cyc - last_deq_cyc);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (res_q.size() == 0) begin
                        errors++;
                        $display("FAIL out_unexpected kv=%h empty=%b", out_kv, out_empty);
                    end else begin
                        r = res_q.pop_front();
                        if ({out_empty, out_kv} !== r) begin
                            errors++;
                            $display("FAIL out_result got empty=%b kv=%h expected empty=%b kv=%h", out_empty, out_kv, r[W], r[W-1:0]);
                        end
                    end
                end
                p_enq = pq_enq; p_deq = pq_deq; p_ov = out_valid; p_busy = pq_busy; p_full = pq_full;
            end
        end
    endtask

    task automatic push_item(input logic [W-1:0] kv);
        in_valid = 1'b1;
        in_kv = kv;
        for (int t = 0; t < 50; t++) begin
            if (in_ready) break;
            tick();
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL push_timeout in_ready=%b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_deq(output logic [W:0] res);
        bit got = 1'b0;
        res = {(W+1){1'b0}};
        dq_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (dq_ready) begin got = 1'b1; break; end
        end
        dq_valid = 1'b0;
        checks++;
        if (!got) begin errors++; $display("FAIL deq_accept_timeout dq_ready=%b expected 1", dq_ready); end
        got = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (out_valid) begin got = 1'b1; break; end
            tick();
        end
        checks++;
        if (!got) begin errors++; $display("FAIL result_timeout out_valid=%b expected 1", out_valid); end
        res = {out_empty, out_kv};
        if (out_ready) tick();
    endtask

    task automatic wait_enq(input int target, input string name);
        for (int t = 0; t < 80; t++) begin
            if (enq_cnt >= target) break;
            tick();
        end
        checks++;
        if (enq_cnt != target) begin
            errors++;
            $display("FAIL %s enq_count=%0d expected %0d", name, enq_cnt, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({in_ready, dq_ready, out_valid, out_empty, pq_enq, pq_deq} !== 6'b100000 || out_kv !== 16'h0000 || pq_kvi !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state ctl=%b out_kv=%h pq_kvi=%h expected ctl=100000 kv=0000", {in_ready, dq_ready, out_valid, out_empty, pq_enq, pq_deq}, out_kv, pq_kvi);
        end
        rst = 1'b0;
        tick(); tick();
        checks++;
        if (in_ready !== 1'b1 || pq_enq !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset in_ready=%b enq=%b out_valid=%b expected 1 0 0", in_ready, pq_enq, out_valid);
        end
    endtask

    task automatic test_enq_order();
        int base = enq_log.size();
        logic [W-1:0] exp_kv [3] = '{16'h0505, 16'h0202, 16'h0909};
        for (int i = 0; i < 3; i++) begin
            push_item(exp_kv[i]);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL enq_in_ready got %b expected 1", in_ready); end
        end
        wait_enq(base + 3, "enq_count");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (enq_log.size() <= base + i || enq_log[base + i] !== exp_kv[i]) begin
                errors++;
                $display("FAIL enq_seq idx=%0d got %h expected %h", i, (enq_log.size() > base + i) ? enq_log[base + i] : 16'hxxxx, exp_kv[i]);
            end
        end
    endtask

    task automatic test_deq_sorted();
        logic [W:0] r;
        logic [KW-1:0] keys [3] = '{8'd2, 8'd5, 8'd9};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_deq(r);
            checks++;
            if (r[W] !== 1'b0 || r[W-1:VW] !== keys[i]) begin
                errors++;
                $display("FAIL deq_sorted idx=%0d got empty=%b key=%h expected empty=0 key=%h", i, r[W], r[W-1:VW], keys[i]);
            end
        end
    endtask

    task automatic test_deq_empty();
        bit got = 1'b0;
        out_ready = 1'b0;
        dq_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (dq_ready) begin got = 1'b1; break; end
        end
        checks++;
        if (!got || out_valid !== 1'b1 || out_empty !== 1'b1 || out_kv !== 16'h0000 || pq_deq !== 1'b0) begin
            errors++;
            $display("FAIL deq_empty dq_ready=%b out_valid=%b out_empty=%b out_kv=%h pq_deq=%b expected 1 1 1 0000 0", dq_ready, out_valid, out_empty, out_kv, pq_deq);
        end
        for (int t = 0; t < 4; t++) begin
            tick();
            checks++;
            if (dq_ready !== 1'b0 || out_valid !== 1'b1 || out_empty !== 1'b1) begin
                errors++;
                $display("FAIL slot_held dq_ready=%b out_valid=%b out_empty=%b expected 0 1 1", dq_ready, out_valid, out_empty);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL slot_release out_valid=%b expected 0", out_valid); end
        tick();
        checks++;
        if (dq_ready !== 1'b1 || out_empty !== 1'b1) begin
            errors++;
            $display("FAIL deq_empty_again dq_ready=%b out_empty=%b expected 1 1", dq_ready, out_empty);
        end
        dq_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_busy_fill();
        int e0 = enq_cnt;
        pq_busy = 1'b1;
        for (int i = 0; i < 4; i++) push_item({8'($urandom), 8'(i)});
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL fifo_full in_ready=%b expected 0", in_ready); end
        in_valid = 1'b1;
        in_kv = 16'hA004;
        for (int t = 0; t < 3; t++) begin
            tick();
            checks++;
            if (in_ready !== 1'b0 || enq_cnt != e0) begin
                errors++;
                $display("FAIL busy_hold in_ready=%b enq_count=%0d expected 0 %0d", in_ready, enq_cnt, e0);
            end
        end
        pq_busy = 1'b0;
        push_item(16'hA004);
        wait_enq(e0 + 5, "busy_drain");
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL busy_in_ready in_ready=%b expected 1", in_ready); end
    endtask

    task automatic test_round_robin();
        logic [W:0] r;
        int e0, d0, b;
        pq_busy = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_item({8'($urandom), 8'hB0 + 8'(i)});
        e0 = enq_cnt;
        b = ops.size();
        dq_valid = 1'b1;
        pq_busy = 1'b0;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (enq_cnt >= e0 + 3) break;
        end
        dq_valid = 1'b0;
        checks++;
        if (ops.size() < b + 2 || ops[b] == ops[b + 1] || enq_cnt != e0 + 3) begin
            errors++;
            $display("FAIL rr_alternate first_ops=%0d,%0d enq_count=%0d expected distinct and %0d", (ops.size() > b) ? ops[b] : -1, (ops.size() > b + 1) ? ops[b + 1] : -1, enq_cnt, e0 + 3);
        end
        repeat (8) tick();
        force_full = 1'b1;
        push_item(16'hC001);
        push_item(16'hC002);
        e0 = enq_cnt;
        d0 = deq_cnt;
        for (int i = 0; i < 3; i++) do_deq(r);
        checks++;
        if (enq_cnt != e0 || deq_cnt != d0 + 3) begin
            errors++;
            $display("FAIL full_deq_only enq=%0d deq=%0d expected %0d %0d", enq_cnt, deq_cnt, e0, d0 + 3);
        end
        force_full = 1'b0;
        wait_enq(e0 + 2, "full_release");
    endtask

    task automatic test_reset_mid();
        bit got = 1'b0;
        force_full = 1'b1;
        for (int i = 0; i < 4; i++) push_item({8'hD0 + 8'(i), 8'(i)});
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_fill in_ready=%b expected 0", in_ready); end
        out_ready = 1'b0;
        dq_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (pq_deq) begin got = 1'b1; break; end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL mid_deq_timeout pq_deq=%b expected 1", pq_deq); end
        rst = 1'b1;
        #1;
        checks++;
        if (pq_deq !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || dq_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset pq_deq=%b out_valid=%b in_ready=%b dq_ready=%b expected 0 0 1 0", pq_deq, out_valid, in_ready, dq_ready);
        end
        dq_valid = 1'b0;
        force_full = 1'b0;
        tick(); tick();
        rst = 1'b0;
        begin
            int e0 = enq_cnt;
            repeat (8) tick();
            checks++;
            if (enq_cnt != e0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_dropped enq_count=%0d out_valid=%b expected %0d 0", enq_cnt, out_valid, e0);
            end
        end
    endtask

    task automatic test_random();
        int t;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 99) < 50);
            in_kv     = 16'($urandom);
            dq_valid  = ($urandom_range(0, 99) < 45);
            out_ready = ($urandom_range(0, 99) < 70);
            pq_busy   = ($urandom_range(0, 99) < 25);
            tick();
        end
        in_valid = 1'b0;
        pq_busy = 1'b0;
        out_ready = 1'b1;
        dq_valid = 1'b1;
        for (t = 0; t < 400; t++) begin
            if (enq_q.size() == 0 && pq_sz == 0) break;
            tick();
        end
        dq_valid = 1'b0;
        repeat (10) tick();
        checks++;
        if (enq_q.size() != 0 || pq_sz != 0 || res_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_drain buffered=%0d pq=%0d results=%0d out_valid=%b expected 0 0 0 0", enq_q.size(), pq_sz, res_q.size(), out_valid);
        end
    endtask

    initial begin
        fork
            monitor_loop();
        join_none
        test_reset();
        test_enq_order();
        test_deq_sorted();
        test_deq_empty();
        test_busy_fill();
        test_round_robin();
        test_reset_mid();
        test_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
